// File: rtl/cpu_mul_seq.sv
// 32x32 multiply sequencer that time-shares one external 16x16 unsigned multiplier cell.
// Accumulates shifted partial products, applies signed correction, returns low or high word.
module cpu_mul_seq #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p
);

    localparam int unsigned W    = 32;
    localparam int unsigned HW   = 16;
    localparam int unsigned AW   = 64;
    localparam int unsigned LAST = MUL_LATENCY - 1;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_XSS = 2'd1;
    localparam logic [1:0] OP_XSU = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CORRECT,
        RESP
    } state_t;

    state_t          state, state_d;
    logic [1:0]      k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   acc_q;
    logic            tag_v [MUL_LATENCY];
    logic [1:0]      tag_k [MUL_LATENCY];

    logic            issue_c, acc_clear_c;
    logic [1:0]      last_k_c;
    logic [W-1:0]    hi_c, corr_c;
    logic [HW-1:0]   mul_a_d, mul_b_d;
    logic            req_ready_d, resp_valid_d, busy_d;
    logic [W-1:0]    resp_result_d;

    // Partial k: a half by k[0], b half by k[1]; LL, HL, LH, HH.
    function automatic logic [HW-1:0] pp_a(input logic [W-1:0] a, input logic [1:0] k);
        return k[0] ? a[31:16] : a[15:0];
    endfunction

    function automatic logic [HW-1:0] pp_b(input logic [W-1:0] b, input logic [1:0] k);
        return k[1] ? b[31:16] : b[15:0];
    endfunction

    function automatic logic [5:0] pp_shift(input logic [1:0] k);
        case (k)
            2'd0:    return 6'd0;
            2'd3:    return 6'd32;
            default: return 6'd16;
        endcase
    endfunction

    // The HH partial cannot touch the low word, so MUL stops after three.
    assign last_k_c = (op_q == OP_MUL) ? 2'd2 : 2'd3;

    // Two's-complement correction of the unsigned high word.
    always_comb begin
        hi_c   = acc_q[63:32];
        corr_c = '0;
        case (op_q)
            OP_XSS:  corr_c = (a_q[31] ? b_q : W'(0)) + (b_q[31] ? a_q : W'(0));
            OP_XSU:  corr_c = a_q[31] ? b_q : W'(0);
            default: corr_c = '0;
        endcase
    end

    always_comb begin
        state_d       = state;
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        mul_a_d       = '0;
        mul_b_d       = '0;
        issue_c       = 1'b0;
        acc_clear_c   = 1'b0;
        resp_valid_d  = resp_valid;
        resp_result_d = resp_result;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d     = ISSUE;
                    a_d         = req_a;
                    b_d         = req_b;
                    op_d        = req_op;
                    k_d         = 2'd0;
                    acc_clear_c = 1'b1;
                    mul_a_d     = pp_a(req_a, 2'd0);
                    mul_b_d     = pp_b(req_b, 2'd0);
                end
            end
            ISSUE: begin
                issue_c = 1'b1;
                if (k_q == last_k_c) begin
                    state_d = DRAIN;
                end else begin
                    k_d     = k_q + 2'd1;
                    mul_a_d = pp_a(a_q, k_d);
                    mul_b_d = pp_b(b_q, k_d);
                end
            end
            DRAIN: begin
                if (tag_v[LAST] && (tag_k[LAST] == last_k_c)) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                state_d       = RESP;
                resp_valid_d  = 1'b1;
                resp_result_d = (op_q == OP_MUL) ? acc_q[31:0] : (hi_c - corr_c);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            mul_a       <= mul_a_d;
            mul_b       <= mul_b_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_result <= resp_result_d;
            busy        <= busy_d;
        end
    end

    // In-flight tags: entry LAST marks the cycle mul_p carries that partial.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
                tag_k[i] <= '0;
            end
        end else begin
            tag_v[0] <= issue_c;
            tag_k[0] <= k_q;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (acc_clear_c) begin
            acc_q <= '0;
        end else if (tag_v[LAST]) begin
            acc_q <= acc_q + (AW'(mul_p) << pp_shift(tag_k[LAST]));
        end
    end

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Bench for cpu_mul_seq: one instance at MUL_LATENCY=1 and one at 3, each with a multiplier cell model.
module tb_cpu_mul_seq;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_XSS = 2'd1;
    localparam logic [1:0] OP_XSU = 2'd2;
    localparam logic [1:0] OP_XUU = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [1:0]  req_op      [2];
    logic [31:0] req_a       [2];
    logic [31:0] req_b       [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_result [2];
    logic        busy        [2];
    logic [15:0] mul_a       [2];
    logic [15:0] mul_b       [2];
    logic [31:0] mul_p       [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_mul_seq #(.MUL_LATENCY(1)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_result(resp_result[0]),
        .busy(busy[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0])
    );

    cpu_mul_seq #(.MUL_LATENCY(3)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_result(resp_result[1]),
        .busy(busy[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1])
    );

    // 16x16 cells with registered output, latency 1 and 3.
    logic [31:0] cell0_q;
    logic [31:0] cell1_q [3];
    always_ff @(posedge clk) begin
        cell0_q    <= {16'b0, mul_a[0]} * {16'b0, mul_b[0]};
        cell1_q[0] <= {16'b0, mul_a[1]} * {16'b0, mul_b[1]};
        cell1_q[1] <= cell1_q[0];
        cell1_q[2] <= cell1_q[1];
    end
    assign mul_p[0] = cell0_q;
    assign mul_p[1] = cell1_q[2];

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (op == OP_XSS || op == OP_XSU) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (op == OP_XSS) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [15:0] half(input logic [31:0] x, input bit hi);
        return hi ? x[31:16] : x[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int d);
        chk("rst_req_ready", 64'(req_ready[d]), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("rst_busy", 64'(busy[d]), 64'd0);
        chk("rst_resp_result", 64'(resp_result[d]), 64'd0);
        chk("rst_mul_a", 64'(mul_a[d]), 64'd0);
        chk("rst_mul_b", 64'(mul_b[d]), 64'd0);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int hold);
        int n, lat_exp, w, j;
        logic [15:0] ea, eb;
        n       = (op == OP_MUL) ? 3 : 4;
        lat_exp = n + 2 + ((d == 0) ? 1 : 3);
        req_op[d]    = op;
        req_a[d]     = a;
        req_b[d]     = b;
        req_valid[d] = 1'b1;
        w = 0;
        while (req_ready[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_before_accept", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_a[d]     = $urandom;
        req_b[d]     = $urandom;
        chk("req_ready_after_accept", 64'(req_ready[d]), 64'd0);
        for (j = 1; j <= 40; j++) begin
            ea = 16'd0;
            eb = 16'd0;
            case (j - 1)
                0: begin ea = half(a, 1'b0); eb = half(b, 1'b0); end
                1: begin ea = half(a, 1'b1); eb = half(b, 1'b0); end
                2: begin ea = half(a, 1'b0); eb = half(b, 1'b1); end
                3: if (n == 4) begin ea = half(a, 1'b1); eb = half(b, 1'b1); end
                default: ;
            endcase
            chk("mul_a", 64'(mul_a[d]), 64'(ea));
            chk("mul_b", 64'(mul_b[d]), 64'(eb));
            if (resp_valid[d] === 1'b1) break;
            @(negedge clk);
        end
        chk("resp_latency", 64'(j), 64'(lat_exp));
        chk("resp_result", 64'(resp_result[d]), 64'(exp_r));
        chk("busy_in_resp", 64'(busy[d]), 64'd1);
        chk("req_ready_in_resp", 64'(req_ready[d]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_resp_valid", 64'(resp_valid[d]), 64'd1);
            chk("hold_resp_result", 64'(resp_result[d]), 64'(exp_r));
            chk("hold_req_ready", 64'(req_ready[d]), 64'd0);
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk("resp_valid_after_hs", 64'(resp_valid[d]), 64'd0);
        chk("req_ready_after_hs", 64'(req_ready[d]), 64'd1);
        chk("busy_after_hs", 64'(busy[d]), 64'd0);
    endtask

    // Abort a MULXUU during partial k=2, then a MUL held across reset.
    task automatic reset_abort(input int d);
        req_op[d]    = OP_XUU;
        req_a[d]     = $urandom;
        req_b[d]     = $urandom;
        req_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_mul_a_k2", 64'(mul_a[d]), 64'(half(req_a[d], 1'b0)));
        #1 reset_n = 1'b0;
        #1 chk_all_zero(d);
        req_op[d]    = OP_MUL;
        req_a[d]     = 32'd3;
        req_b[d]     = 32'd4;
        req_valid[d] = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        chk("ready_before_first_edge", 64'(req_ready[d]), 64'd0);
        @(negedge clk);
        chk("ready_first_edge", 64'(req_ready[d]), 64'd1);
        chk("resp_valid_no_abort_resp", 64'(resp_valid[d]), 64'd0);
        run_op(d, OP_MUL, 32'd3, 32'd4, 32'h0000_000C, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'(($urandom_range(0, 1) != 0) ? 32'h0000_FFFF : 32'hFFFF_0000);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_op[d]     = 2'd0;
            req_a[d]      = 32'd0;
            req_b[d]      = 32'd0;
            resp_ready[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_all_zero(0);
        chk_all_zero(1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset0", 64'(req_ready[0]), 64'd1);
        chk("ready_after_reset1", 64'(req_ready[1]), 64'd1);

        for (int d = 0; d < 2; d++) begin
            run_op(d, OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0);
            run_op(d, OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
            run_op(d, OP_XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
            run_op(d, OP_XSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
            run_op(d, OP_XSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
            run_op(d, OP_XUU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 10);
            reset_abort(d);
            for (int i = 0; i < 16; i++) begin
                rop = 2'($urandom_range(0, 3));
                ra  = pick_operand();
                rb  = pick_operand();
                run_op(d, rop, ra, rb, ref_result(rop, ra, rb), int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
